// File: rtl/sram_pipe_model.sv
// Purpose: behavioural model of the board's external SRAM (byte lanes, pipelined reads, access counters, conflict flag).
// Latency: read data is driven RD_LAT cycles after launch; writes land at the launching edge.
// Backpressure: none; one access per cycle, bus drive follows sram_oe_b/sram_we_b combinationally.
// Build option: define SRAM_RAND_INIT_EN to fill memory with random words on reset (only when CLEAR_ON_RST = 1).
module sram_pipe_model #(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 16,
    parameter int RD_LAT       = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     sram_addr,
    inout  wire  [DATA_W-1:0]     sram_io,
    input  logic                  sram_ce_b,
    input  logic                  sram_we_b,
    input  logic                  sram_oe_b,
    input  logic [DATA_W/8-1:0]   sram_be_b,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count,
    output logic                  bus_conflict
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LAST  = RD_LAT - 1;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Read pipeline: stage 0 is filled at launch, stage LAST feeds the bus.
    logic [RD_LAT-1:0] r_vld;
    logic [DATA_W-1:0] r_pipe_dat [RD_LAT];
    logic [NB-1:0]     r_pipe_be  [RD_LAT];

    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;
    logic        r_bus_conflict;

    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_any_lane;
    logic [NB-1:0] w_lane_drv;

    assign w_wr_en    = ~sram_ce_b & ~sram_we_b;
    assign w_rd_en    = ~sram_ce_b &  sram_we_b;
    assign w_any_lane = ~(&sram_be_b);

    // Memory array: optional clear/fill on reset, byte-lane masked writes otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLEAR_ON_RST != 0) begin
                for (int w = 0; w < DEPTH; w++) begin
`ifdef SRAM_RAND_INIT_EN
                    r_mem[w] <= DATA_W'($random);
`else
                    r_mem[w] <= '0;
`endif
                end
            end
        end else if (w_wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (!sram_be_b[b]) begin
                    r_mem[sram_addr][8*b +: 8] <= sram_io[8*b +: 8];
                end
            end
        end
    end

    // Valid bits shift every cycle; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_rd_en;
            for (int k = 1; k < RD_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    // Data/lane payload shifts alongside the valid bits; stage 0 snapshots the old word (read-first).
    always_ff @(posedge clk) begin
        r_pipe_dat[0] <= r_mem[sram_addr];
        r_pipe_be[0]  <= sram_be_b;
        for (int k = 1; k < RD_LAT; k++) begin
            r_pipe_dat[k] <= r_pipe_dat[k-1];
            r_pipe_be[k]  <= r_pipe_be[k-1];
        end
    end

    // Saturating access counters; writes with every lane masked are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (w_rd_en && (r_rd_count != 32'hFFFF_FFFF)) begin
                r_rd_count <= r_rd_count + 32'd1;
            end
            if (w_wr_en && w_any_lane && (r_wr_count != 32'hFFFF_FFFF)) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    // Sticky flag: host wrote while the model had data due and output enable asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_conflict <= 1'b0;
        end else if (w_wr_en && !sram_oe_b && r_vld[LAST]) begin
            r_bus_conflict <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign w_lane_drv[gi] = r_vld[LAST] & ~sram_oe_b & sram_we_b & ~r_pipe_be[LAST][gi];
            assign sram_io[8*gi +: 8] = w_lane_drv[gi] ? r_pipe_dat[LAST][8*gi +: 8] : 8'bz;
        end
    endgenerate

    assign rd_count     = r_rd_count;
    assign wr_count     = r_wr_count;
    assign bus_conflict = r_bus_conflict;

endmodule

// File: tb/tb_sram_pipe_model.sv
// Purpose: self-checking bench for sram_pipe_model against a queue-based reference of timed reads.
// Latency: expectations are evaluated once per cycle, mid-cycle, after inputs settle.
// Backpressure: none; the bench owns the data bus only during write cycles.
module tb_sram_pipe_model;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 3;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] sram_addr;
    wire  [DATA_W-1:0] sram_io;
    logic              sram_ce_b;
    logic              sram_we_b;
    logic              sram_oe_b;
    logic [1:0]        sram_be_b;
    logic [31:0]       rd_count;
    logic [31:0]       wr_count;
    logic              bus_conflict;

    logic              tb_drv;
    logic [DATA_W-1:0] tb_dat;

    assign sram_io = tb_drv ? tb_dat : 16'bz;

    sram_pipe_model #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .RD_LAT       (RD_LAT),
        .CLEAR_ON_RST (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sram_addr    (sram_addr),
        .sram_io      (sram_io),
        .sram_ce_b    (sram_ce_b),
        .sram_we_b    (sram_we_b),
        .sram_oe_b    (sram_oe_b),
        .sram_be_b    (sram_be_b),
        .rd_count     (rd_count),
        .wr_count     (wr_count),
        .bus_conflict (bus_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: memory image, counters, and reads waiting for the cycle in which they are due.
    typedef struct {
        int          due;
        logic [15:0] dat;
        logic [1:0]  be;
    } rd_t;

    logic [15:0] m_mem [2**ADDR_W];
    rd_t         q[$];
    logic [31:0] m_rd;
    logic [31:0] m_wr;
    logic        m_conf;
    int          n_edges;

    int n_cmp;
    int n_mis;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, n_edges);
        end
    endtask

    // Undriven bits read as 0 so a floating bus and a driven bus can be compared numerically.
    function automatic logic [15:0] bus_img(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = (v[i] === 1'b1);
        return r;
    endfunction

    task automatic model_reset();
        m_rd   = '0;
        m_wr   = '0;
        m_conf = 1'b0;
        q.delete();
        for (int i = 0; i < 2**ADDR_W; i++) m_mem[i] = '0;
    endtask

    // One clock cycle: apply inputs, check the cycle's outputs, then advance the reference at the edge.
    task automatic step(input logic r_i, input logic ce, input logic we, input logic oe,
                        input logic [1:0] be, input logic [ADDR_W-1:0] a, input logic [15:0] d);
        logic [15:0] exp_bus;
        logic        have;
        rd_t         cur;
        @(negedge clk);
        rst       = r_i;
        sram_ce_b = ce;
        sram_we_b = we;
        sram_oe_b = oe;
        sram_be_b = be;
        sram_addr = a;
        tb_dat    = d;
        tb_drv    = ~we;
        #1;
        have = 1'b0;
        cur  = '{due: 0, dat: 16'h0, be: 2'b11};
        foreach (q[k]) if (q[k].due == n_edges) begin have = 1'b1; cur = q[k]; end
        exp_bus = '0;
        if (!we) begin
            exp_bus = d;
        end else if (have && !oe) begin
            for (int l = 0; l < 2; l++) if (!cur.be[l]) exp_bus[8*l +: 8] = cur.dat[8*l +: 8];
        end
        chk("bus", {16'h0, bus_img(sram_io)}, {16'h0, exp_bus});
        chk("rd_count", rd_count, m_rd);
        chk("wr_count", wr_count, m_wr);
        chk("bus_conflict", {31'h0, bus_conflict}, {31'h0, m_conf});
        @(posedge clk);
        if (r_i) begin
            model_reset();
        end else begin
            if (!ce && !we) begin
                if (!oe && have) m_conf = 1'b1;
                for (int l = 0; l < 2; l++) if (!be[l]) m_mem[a][8*l +: 8] = d[8*l +: 8];
                if (be != 2'b11 && m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 1;
            end
            if (!ce && we) begin
                q.push_back('{due: n_edges + RD_LAT, dat: m_mem[a], be: be});
                if (m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 1;
            end
        end
        n_edges++;
        while (q.size() > 0 && q[0].due < n_edges) void'(q.pop_front());
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [15:0] d, input logic [1:0] be, input logic oe);
        step(1'b0, 1'b0, 1'b0, oe, be, a, d);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [1:0] be);
        step(1'b0, 1'b0, 1'b1, 1'b0, be, a, 16'h0);
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, '0, 16'h0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, '0, 16'h0);
    endtask

    initial begin
        n_cmp     = 0;
        n_mis     = 0;
        n_edges   = 0;
        rst       = 1'b1;
        sram_ce_b = 1'b1;
        sram_we_b = 1'b1;
        sram_oe_b = 1'b1;
        sram_be_b = 2'b11;
        sram_addr = '0;
        tb_dat    = '0;
        tb_drv    = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state, then a full-word write and a delayed read-back.
        do_reset();
        wr(8'h10, 16'hA5C3, 2'b00, 1'b1);
        rd(8'h10, 2'b00);
        repeat (RD_LAT + 1) idle();

        // Byte-lane merge and lane-masked output drive.
        wr(8'h05, 16'h1234, 2'b00, 1'b1);
        wr(8'h05, 16'hFFFF, 2'b10, 1'b1);
        rd(8'h05, 2'b00);
        rd(8'h05, 2'b01);
        repeat (RD_LAT + 1) idle();

        // Back-to-back reads, then a read whose address is rewritten while in flight.
        wr(8'h01, 16'h0001, 2'b00, 1'b1);
        wr(8'h02, 16'h0002, 2'b00, 1'b1);
        wr(8'h03, 16'h0003, 2'b00, 1'b1);
        rd(8'h01, 2'b00);
        rd(8'h02, 2'b00);
        rd(8'h03, 2'b00);
        repeat (RD_LAT + 1) idle();
        rd(8'h02, 2'b00);
        wr(8'h02, 16'hBEEF, 2'b00, 1'b1);
        repeat (RD_LAT + 1) idle();

        // Reset with reads in flight: bus stays Z, counters and memory cleared.
        rd(8'h10, 2'b00);
        rd(8'h02, 2'b00);
        do_reset();
        repeat (RD_LAT + 1) idle();
        rd(8'h10, 2'b00);
        repeat (RD_LAT + 1) idle();

        // Host write with oe asserted while read data is due: sticky conflict until reset.
        wr(8'h20, 16'h5A5A, 2'b00, 1'b1);
        rd(8'h20, 2'b00);
        repeat (RD_LAT - 1) idle();
        wr(8'h21, 16'h0F0F, 2'b00, 1'b0);
        repeat (4) idle();
        do_reset();
        idle();

        // Read counter saturation.
        #1;
        dut.r_rd_count = 32'hFFFF_FFFE;
        m_rd           = 32'hFFFF_FFFE;
        rd(8'h01, 2'b00);
        rd(8'h02, 2'b00);
        rd(8'h03, 2'b00);
        repeat (RD_LAT + 1) idle();
        do_reset();

        // Randomised traffic over a small address window, with occasional resets.
        for (int it = 0; it < 800; it++) begin
            logic        r_i, ce, we, oe;
            logic [1:0]  be;
            logic [7:0]  a;
            logic [15:0] d;
            r_i = ($urandom_range(0, 99) < 2);
            ce  = ($urandom_range(0, 4) == 0);
            we  = $urandom_range(0, 1) != 0;
            oe  = ($urandom_range(0, 3) == 0);
            be  = 2'($urandom_range(0, 3));
            a   = 8'($urandom_range(0, 15));
            d   = 16'($urandom);
            step(r_i, ce, we, oe, be, a, d);
        end
        repeat (RD_LAT + 1) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
